// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
// Shared types, sizing constants and helpers for the FIFO drain serializer.
// Contents:
//   drain_state_t  FSM state encoding (IDLE, SEND, PARITY)
//   BEATS          output beats per FIFO word at the default widths
//   BEAT_CNT_W     width of the beat counter (never less than 1 bit)
//   parity_beat()  builds the trailing parity beat for a word
// PARITY is only reachable when DRAIN_PARITY_EN is defined.
package fifo_drain_pkg;

  localparam int DRAIN_DATA_W = 40;
  localparam int DRAIN_OUT_W  = 8;
  localparam int BEATS        = DRAIN_DATA_W / DRAIN_OUT_W;
  localparam int BEAT_CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    PARITY = 2'd2
  } drain_state_t;

  // Even parity of the whole word in bit 0, all upper bits zero.
  function automatic logic [DRAIN_OUT_W-1:0] parity_beat(input logic [DRAIN_DATA_W-1:0] word);
    logic [DRAIN_OUT_W-1:0] beat;
    beat    = '0;
    beat[0] = ^word;
    return beat;
  endfunction

endpackage

// File: rtl/drain_shreg.sv
// drain_shreg
// Word-wide shift register feeding the output beats, LSB beat first.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high clear
//   load       capture load_data (wins over shift)
//   shift      shift right by OUT_W with zero fill
//   load_data  DATA_W-bit word to capture
//   beat       lowest OUT_W bits, the beat currently on offer
module drain_shreg #(
  parameter int DATA_W = 40,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic [OUT_W-1:0]  beat
);

  logic [DATA_W-1:0] data_q;

  // Load has priority so a reload on the final beat replaces the old word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= data_q >> OUT_W;
    end
  end

  assign beat = data_q[OUT_W-1:0];

endmodule

// File: rtl/fifo_drain_serializer.sv
// fifo_drain_serializer
// Read-side controller for the word FIFO: pops words while draining is
// enabled and sends each one LSB-first as OUT_W-bit beats on a
// valid/ready stream.
// Ports:
//   clk, reset      clock and asynchronous active-high reset
//   drain_en        allow popping new words (a word in flight always finishes)
//   fifo_dataout    show-ahead FIFO head word, fifo_empty  FIFO empty flag
//   fifo_r_en       pop strobe, FIFO advances on the edge where it is high
//   out_data/out_valid/out_ready  beat stream toward the narrow link
//   busy            state is not IDLE
//   word_done       one-cycle pulse after the last beat of a word is taken
// Configuration macro: DRAIN_PARITY_EN adds a trailing even-parity beat.
module fifo_drain_serializer
  import fifo_drain_pkg::*;
#(
  parameter int DATA_W = DRAIN_DATA_W,
  parameter int OUT_W  = DRAIN_OUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drain_en,
  input  logic [DATA_W-1:0] fifo_dataout,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              word_done
);

  localparam int NBEATS = DATA_W / OUT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  drain_state_t     state, state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic [OUT_W-1:0] shreg_beat;
  logic             load, shift, done_set;
  logic             handshake, last_beat, pop_ok;

`ifdef DRAIN_PARITY_EN
  logic             parity_q;
  logic [OUT_W-1:0] pop_parity;
  assign pop_parity = parity_beat(fifo_dataout);
`endif

  drain_shreg #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (fifo_dataout),
    .beat      (shreg_beat)
  );

  // Reset gates the pop so the FIFO never loses a word we are about to discard.
  assign pop_ok    = drain_en & ~fifo_empty & ~reset;
  assign handshake = out_valid & out_ready;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    case (state)
      SEND: begin
        out_valid = 1'b1;
        out_data  = shreg_beat;
      end
`ifdef DRAIN_PARITY_EN
      PARITY: begin
        out_valid = 1'b1;
        out_data  = {{(OUT_W-1){1'b0}}, parity_q};
      end
`endif
      default: ;
    endcase
  end

  // End-of-word decision: either reload the next word in the same cycle
  // (no bubble between words) or fall back to IDLE.
  always_comb begin
    state_next = state;
    fifo_r_en  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (pop_ok) begin
          fifo_r_en  = 1'b1;
          load       = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (!last_beat) begin
            shift = 1'b1;
          end else begin
`ifdef DRAIN_PARITY_EN
            state_next = PARITY;
`else
            done_set = 1'b1;
            if (pop_ok) begin
              fifo_r_en = 1'b1;
              load      = 1'b1;
            end else begin
              state_next = IDLE;
            end
`endif
          end
        end
      end
`ifdef DRAIN_PARITY_EN
      PARITY: begin
        if (handshake) begin
          done_set = 1'b1;
          if (pop_ok) begin
            fifo_r_en  = 1'b1;
            load       = 1'b1;
            state_next = SEND;
          end else begin
            state_next = IDLE;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Beat counter restarts on every pop; word_done is registered so it lands
  // in the cycle after the final beat is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= done_set;
      if (load) begin
        beat_cnt <= '0;
      end else if (shift) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

`ifdef DRAIN_PARITY_EN
  // Parity is captured from the word at pop, before the shifter mangles it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= pop_parity[0];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_drain_serializer.sv
module tb_fifo_drain_serializer;
  import fifo_drain_pkg::*;

  localparam int DATA_W = DRAIN_DATA_W;
  localparam int OUT_W  = DRAIN_OUT_W;
`ifdef DRAIN_PARITY_EN
  localparam int WORD_CYCLES = BEATS + 1;
`else
  localparam int WORD_CYCLES = BEATS;
`endif

  typedef struct {
    logic [OUT_W-1:0] beat;
    bit               last;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              drain_en;
  logic [DATA_W-1:0] fifo_dataout;
  logic              fifo_empty;
  logic              fifo_r_en;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              word_done;

  logic [DATA_W-1:0] fmem [0:31];
  int   wptr = 0;
  int   rptr = 0;
  int   popCount = 0;
  int   beatsSeen = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];
  bit   expDone = 0;
  exp_t monE;
  bit   monNext;

  fifo_drain_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .drain_en     (drain_en),
    .fifo_dataout (fifo_dataout),
    .fifo_empty   (fifo_empty),
    .fifo_r_en    (fifo_r_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .word_done    (word_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Show-ahead FIFO model: head word visible combinationally.
  assign fifo_empty   = (rptr == wptr);
  assign fifo_dataout = fifo_empty ? '0 : fmem[rptr % 32];

  always @(posedge clk) begin
    if (fifo_r_en) begin
      rptr <= rptr + 1;
      popCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Push a word into the FIFO and queue the first nExp beats it should produce.
  task automatic applyStimulus(input logic [DATA_W-1:0] word, input int nExp);
    exp_t e;
    fmem[wptr % 32] = word;
    wptr++;
    for (int i = 0; i < nExp; i++) begin
      e.beat = word[i*OUT_W +: OUT_W];
      e.last = (i == WORD_CYCLES - 1);
      expQ.push_back(e);
    end
`ifdef DRAIN_PARITY_EN
    if (nExp == BEATS) begin
      e.beat = OUT_W'(^word);
      e.last = 1'b1;
      expQ.push_back(e);
    end
`endif
  endtask

  task automatic waitIdle(input int maxCycles, input int keep, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((busy || expQ.size() != keep) && n < maxCycles);
    checkOutput("idle_busy", busy, 0);
    checkOutput("expq_level", expQ.size(), keep);
  endtask

  // Monitor: inputs only change just after a rising edge, so what is seen at
  // the falling edge is what the next rising edge will act on.
  always @(negedge clk) begin
    monNext = 1'b0;
    if (reset) begin
      checkOutput("reset_valid", out_valid, 0);
      checkOutput("reset_ren", fifo_r_en, 0);
    end else begin
      checkOutput("word_done", word_done, expDone);
      if (!out_valid) begin
        checkOutput("idle_ren", fifo_r_en, drain_en && !fifo_empty);
      end else if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", out_data);
      end else begin
        monE = expQ[0];
        checkOutput(out_ready ? "beat_data" : "stall_hold", out_data, monE.beat);
        checkOutput("send_ren", fifo_r_en, out_ready && monE.last && drain_en && !fifo_empty);
        if (out_ready) begin
          void'(expQ.pop_front());
          beatsSeen++;
          monNext = monE.last;
        end
      end
    end
    expDone = monNext;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, p0, b0, cnt;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; drain_en = 1'b0; out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_fifo_r_en", fifo_r_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_word_done", word_done, 0);
    reset = 1'b0;

    $display("[TB] empty FIFO with drain enabled");
    drain_en = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    checkOutput("empty_busy", busy, 0);
    checkOutput("empty_valid", out_valid, 0);
    checkOutput("empty_pops", popCount, 0);

    $display("[TB] single word");
    p0 = popCount;
    applyStimulus(40'h12_3456_789A, BEATS);
    waitIdle(50, 0, n);
    checkOutput("single_cycles", n, WORD_CYCLES + 1);
    checkOutput("single_pops", popCount - p0, 1);

    $display("[TB] three words back-to-back");
    p0 = popCount;
    applyStimulus(40'h01_0203_0405, BEATS);
    applyStimulus(40'hA5_A5A5_A5A5, BEATS);
    applyStimulus(40'hFF_EEDD_CCBB, BEATS);
    waitIdle(100, 0, n);
    checkOutput("b2b_cycles", n, 3 * WORD_CYCLES + 1);
    checkOutput("b2b_pops", popCount - p0, 3);

    $display("[TB] backpressure");
    p0 = popCount;
    b0 = beatsSeen;
    applyStimulus(40'h0F_1E2D_3C4B, BEATS);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      out_ready = pat[i];
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    waitIdle(50, 0, n);
    checkOutput("stall_pops", popCount - p0, 1);
    checkOutput("stall_beats", beatsSeen - b0, WORD_CYCLES);

    $display("[TB] reset mid-word");
    p0 = popCount;
    b0 = beatsSeen;
    applyStimulus(40'hAA_BBCC_DDEE, 2);
    cnt = 0;
    while (beatsSeen < b0 + 2 && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    checkOutput("rst_mid_progress", beatsSeen - b0, 2);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_busy", busy, 0);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    applyStimulus(40'h55_6677_8899, BEATS);
    waitIdle(50, 0, n);
    checkOutput("rst_mid_pops", popCount - p0, 2);

    $display("[TB] drain_en dropped mid-word");
    p0 = popCount;
    applyStimulus(40'h10_2030_4050, BEATS);
    applyStimulus(40'h60_7080_90A0, BEATS);
    @(posedge clk); #1;
    drain_en = 1'b0;
    waitIdle(50, WORD_CYCLES, n);
    checkOutput("drain_off_pops", popCount - p0, 1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("drain_off_busy", busy, 0);
    drain_en = 1'b1;
    waitIdle(50, 0, n);
    checkOutput("drain_on_pops", popCount - p0, 2);

    $display("[TB] parity words");
    applyStimulus(40'h00_0000_0007, BEATS);
    waitIdle(50, 0, n);
    applyStimulus(40'h00_0000_0003, BEATS);
    waitIdle(50, 0, n);

    repeat (2) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Read-side controller for the 40-bit, 32-entry word FIFO. It pops words from the FIFO whenever the FIFO is non-empty and draining is enabled. Each word is emitted LSB-first as a sequence of OUT_W-bit beats on a valid/ready stream toward the narrower downstream link. It is the consumer counterpart of the FIFO's write-side producer.

## Interface
- DATA_W, 40: FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 8: output beat width. BEATS = DATA_W/OUT_W (5 at defaults).
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- drain_en  input  1  enables popping new words; a word already in progress always completes.
- fifo_dataout  input  DATA_W  FIFO head word, combinational show-ahead, valid while fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_r_en  output  1  pop strobe; the FIFO advances its read pointer on the clk edge where this is 1.
- out_data  output  OUT_W  current beat.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both 1 at a rising edge.
- busy  output  1  high whenever state is not IDLE.
- word_done  output  1  one-cycle pulse, registered, in the cycle after the final beat of a word is accepted.

## Operation
- State machine states: IDLE, SEND, and PARITY (PARITY exists only with the macro described under Configuration).
- IDLE:
  - fifo_r_en = drain_en & ~fifo_empty, combinational.
  - On an edge with fifo_r_en=1, latch fifo_dataout into the shift register, clear beat_cnt to 0, and go to SEND.
- SEND:
  - out_valid=1; out_data = shreg[OUT_W-1:0].
  - On handshake with beat_cnt < BEATS-1: shift shreg right by OUT_W (zero fill) and increment beat_cnt.
  - On handshake of the final beat (beat_cnt = BEATS-1), without parity:
    - if drain_en & ~fifo_empty: fifo_r_en=1 in that same cycle, reload shreg, beat_cnt=0, stay in SEND;
    - otherwise go to IDLE.
  - On handshake of the final beat with parity enabled: go to PARITY instead; no pop occurs.
- PARITY: on handshake, apply the same reload-or-IDLE decision as the final beat in SEND.
- fifo_r_en is never asserted while fifo_empty=1, and never more than once per word.
- beat_cnt width is $clog2(BEATS), minimum 1 bit.

## Timing
- Reset values: out_valid=0, out_data=0, fifo_r_en=0, busy=0, word_done=0, state=IDLE, shreg=0, beat_cnt=0.
- fifo_r_en is forced to 0 while reset is high.
- Latency: pop edge to first out_valid = 1 cycle.
- Throughput: with out_ready held high and the FIFO never empty, one word per BEATS cycles (BEATS+1 with parity). There are no bubbles between words.
- Backpressure: while out_valid=1 and out_ready=0, out_data, beat_cnt and state hold, and no pop occurs.
- drain_en deasserted mid-word: the remaining beats are still sent, then the block goes to IDLE.
- The FIFO going empty during a word has no effect until the final-beat decision.
- Reset asserted mid-word: the partial word is discarded and out_valid drops immediately. The FIFO does not re-present the discarded word.

## Configuration
- DRAIN_PARITY_EN defined: after the last data beat, an extra beat is sent.
  - Beat value: {(OUT_W-1) zeros, ^word}, where ^word is even parity over the full DATA_W-bit word captured at pop.
  - The parity bit is stored in a 1-bit register at pop.
- DRAIN_PARITY_EN undefined: there is no PARITY state, no parity register and no extra beat.

## Structure
- Shared package fifo_drain_pkg contains:
  - state enum (IDLE, SEND, PARITY);
  - localparam BEATS and beat_cnt width;
  - function parity_beat(word) returning the OUT_W-bit parity beat.
- One natural sub-module, drain_shreg: a DATA_W-bit register with load/shift/hold, parameterized by DATA_W and OUT_W. The FSM stays in the top module.

## Test plan
- Reset, then FIFO empty with drain_en=1 for 10 cycles -> fifo_r_en=0, out_valid=0, busy=0.
- One word 40'h12_3456_789A, out_ready=1 -> fifo_r_en pulses once; beats 9A,78,56,34,12 on consecutive cycles; word_done one cycle after the beat 12.
- Three words back-to-back, out_ready=1 -> 15 consecutive valid beats; fifo_r_en high exactly on the final-beat cycles of words 1 and 2 plus the initial pop.
- out_ready toggling 1,0,0,1 during a word -> out_data held through the stalls; no lost or duplicated beats; no pop while stalled.
- Reset pulsed after beat 2 of 40'hAABB_CCDD_EE -> out_valid=0 asynchronously. After release, the next FIFO word is sent starting from its first beat.
- DRAIN_PARITY_EN with word 40'h00_0000_0007 -> beats 07,00,00,00,00,01. With 40'h03 -> final parity beat is 00.
